// File: rtl/bitwise_op_engine.sv
// rtl/bitwise_op_engine.sv - WIDTH-bit bitwise operation engine with iterative rotate and popcount
module bitwise_op_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_err,
    output logic             busy
);

    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    pop_q, pop_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] rev_a;
    logic [WIDTH-1:0] rot_l1;
    logic [WIDTH-1:0] rot_r1;
    logic [CW-1:0]    pop_next;
    logic             accept;

    assign in_ready  = rst_n && ena && (state_q == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign result    = result_q;
    assign out_err   = err_q;

    always_comb begin
        rev_a = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_a[i] = a[WIDTH-1-i];
        end
    end

    always_comb begin
        single_res = '0;
        case (op)
            4'd0:    single_res = ~a;
            4'd1:    single_res = a & b;
            4'd2:    single_res = a | b;
            4'd3:    single_res = a ^ b;
            4'd4:    single_res = ~(a & b);
            4'd5:    single_res = ~(a | b);
            4'd6:    single_res = ~(a ^ b);
            4'd7:    single_res = a;
            4'd11:   single_res = rev_a;
            default: single_res = '0;
        endcase
    end

    // One-bit step of each iterative op; the same shift register serves rotate and popcount.
    assign rot_l1   = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
    assign rot_r1   = {work_q[0], work_q[WIDTH-1:1]};
    assign pop_next = pop_q + {{(CW-1){1'b0}}, work_q[0]};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        pop_d    = pop_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = op;
                    work_d = a;
                    pop_d  = '0;
                    err_d  = 1'b0;
                    case (op)
                        4'd8, 4'd9: begin
                            if (b[LW-1:0] == '0) begin
                                result_d = a;
                                state_d  = S_DONE;
                            end else begin
                                cnt_d   = {1'b0, b[LW-1:0]};
                                state_d = S_BUSY;
                            end
                        end
                        4'd10: begin
                            cnt_d   = CW'(WIDTH);
                            state_d = S_BUSY;
                        end
                        4'd12, 4'd13, 4'd14, 4'd15: begin
                            result_d = '0;
                            err_d    = 1'b1;
                            state_d  = S_DONE;
                        end
                        default: begin
                            result_d = single_res;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                case (op_q)
                    4'd8:    work_d = rot_l1;
                    4'd9:    work_d = rot_r1;
                    default: begin
                        work_d = work_q >> 1;
                        pop_d  = pop_next;
                    end
                endcase
                // Result is published only on the final step so it never shows a partial value.
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    case (op_q)
                        4'd8:    result_d = rot_l1;
                        4'd9:    result_d = rot_r1;
                        default: result_d = WIDTH'(pop_next);
                    endcase
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            pop_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            pop_q    <= pop_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_bitwise_op_engine.sv
// tb/tb_bitwise_op_engine.sv - randomized and directed checks of bitwise_op_engine against a latency/result model
module tb_bitwise_op_engine;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         out_err;
    logic         busy;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model: a pending op, cycles still to spend iterating, and the value result must hold.
    bit           m_pend = 1'b0;
    int           m_rem = 0;
    logic [W-1:0] m_res = '0;
    bit           m_err = 1'b0;
    logic [W-1:0] m_hold = '0;

    bitwise_op_engine #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int k;
        logic [W-1:0] r;
        k = int'(y) % W;
        r = '0;
        case (o)
            4'd0: r = ~x;
            4'd1: r = x & y;
            4'd2: r = x | y;
            4'd3: r = x ^ y;
            4'd4: r = ~(x & y);
            4'd5: r = ~(x | y);
            4'd6: r = ~(x ^ y);
            4'd7: r = x;
            4'd8: r = W'((int'(x) << k) | (int'(x) >> (W - k)));
            4'd9: r = W'((int'(x) >> k) | (int'(x) << (W - k)));
            4'd10: r = W'($countones(x));
            4'd11: for (int i = 0; i < W; i++) r[i] = x[W-1-i];
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [3:0] o, input logic [W-1:0] y);
        if (o == 4'd8 || o == 4'd9) return int'(y) % W;
        if (o == 4'd10) return W;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (rst_n && started) begin
            chk("in_ready", int'(in_ready), int'(!m_pend && ena));
            chk("out_valid", int'(out_valid), int'(m_pend && m_rem == 0));
            chk("busy", int'(busy), int'(m_pend && m_rem > 0));
            chk("result_hold", int'(result), int'(m_hold));
            if (m_pend && m_rem == 0) chk("out_err", int'(out_err), int'(m_err));
            if (m_pend) begin
                if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) m_hold = m_res;
                end else if (out_ready) begin
                    m_pend = 1'b0;
                end
            end else if (in_valid && ena) begin
                m_pend = 1'b1;
                m_res  = ref_result(op, a, b);
                m_err  = (op >= 4'd12);
                m_rem  = ref_latency(op, b);
                if (m_rem == 0) m_hold = m_res;
            end
        end
    end

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_r, input bit exp_e, input int exp_lat);
        int n;
        @(posedge clk) #1;
        op = o; a = x; b = y; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk) #1;
            n++;
        end
        if (n >= 100) chk("accept_timeout", 0, 1);
        @(posedge clk) #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk) #1;
            n++;
        end
        chk("lit_latency", n, exp_lat);
        chk("lit_result", int'(result), int'(exp_r));
        chk("lit_err", int'(out_err), int'(exp_e));
    endtask

    initial begin
        int n;
        #2;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_busy", int'(busy), 0);
        #21;
        rst_n = 1'b1;
        started = 1'b1;

        run_op(4'd0, 8'h5A, 8'h00, 8'hA5, 1'b0, 1);
        run_op(4'd8, 8'h81, 8'h03, 8'h0C, 1'b0, 4);
        run_op(4'd8, 8'h81, 8'h08, 8'h81, 1'b0, 1);
        run_op(4'd10, 8'hF3, 8'h00, 8'h06, 1'b0, 9);
        run_op(4'd10, 8'hFF, 8'h00, 8'h08, 1'b0, 9);
        run_op(4'd10, 8'h00, 8'h00, 8'h00, 1'b0, 9);
        run_op(4'd13, 8'h12, 8'h34, 8'h00, 1'b1, 1);
        run_op(4'd1, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1);
        run_op(4'd11, 8'h1E, 8'h00, 8'h78, 1'b0, 1);
        run_op(4'd9, 8'h01, 8'h01, 8'h80, 1'b0, 2);

        // Backpressure on an XOR result.
        @(posedge clk) #1;
        out_ready = 1'b0;
        op = 4'd3; a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_result", int'(result), 8'hCC);
            chk("bp_in_ready", int'(in_ready), 0);
            @(posedge clk) #1;
        end
        out_ready = 1'b1;
        @(posedge clk) #1;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);

        // Asynchronous reset two cycles into a rotate.
        op = 4'd9; a = 8'hC3; b = 8'h07; in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        @(posedge clk) #1;
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        m_pend = 1'b0;
        m_hold = '0;
        #1;
        chk("arst_in_ready", int'(in_ready), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_result", int'(result), 0);
        chk("arst_out_err", int'(out_err), 0);
        chk("arst_busy", int'(busy), 0);
        @(posedge clk);
        @(posedge clk) #3;
        rst_n = 1'b1;
        @(posedge clk) #1;
        chk("post_rst_ready", int'(in_ready), 1);
        chk("post_rst_valid", int'(out_valid), 0);

        // ena drops during a popcount; the op still completes.
        op = 4'd10; a = 8'hB5; b = 8'h00; in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        ena = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk) #1;
            n++;
        end
        chk("ena_pop_result", int'(result), 5);
        chk("ena_pop_valid", int'(out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            chk("ena_low_ready", int'(in_ready), 0);
        end
        ena = 1'b1;

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk) #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            op        = 4'($urandom_range(0, 15));
            a         = W'($urandom);
            b         = W'($urandom);
            ena       = ($urandom_range(0, 9) < 9);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
